// File: rtl/dmi_bridge_pkg.sv
// Shared types for the DMI request bridge.
//   DMI_ADDR_W / DMI_DATA_W : DMI register address and data widths
//   state_e                 : bridge FSM states
//   dmi_req_t               : one buffered DMI access {write, addr, wdata}
package dmi_bridge_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] wdata;
  } dmi_req_t;

endpackage

// File: rtl/dmi_req_fifo.sv
// Small synchronous request FIFO for the DMI bridge.
//   clock, rst_n : core clock, synchronous active-low reset
//   push, wdata  : enqueue; taken when not full, or when full with a pop
//                  in the same cycle
//   pop, rdata   : dequeue; rdata is the head entry (combinational)
//   flush        : empties the FIFO; wins over push and pop
//   full, empty, count : occupancy
module dmi_req_fifo
  import dmi_bridge_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  dmi_req_t      wdata,
  output dmi_req_t      rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  dmi_req_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmi_req_bridge.sv
// Core-clock bridge between the JTAG DMI wrapper register strobes and the
// debug-module register file.
//   clock, io_core_rst_n        : core clock, synchronous active-low reset
//   io_dmi_reg_*                : access strobe + fields from the wrapper
//   io_dmi_hard_reset           : level flush of queue, FSM and flags
//   io_dmi_rd_data              : last read response, held for the wrapper
//   io_dm_req_*                 : valid/ready request channel to the DM
//   io_dm_rsp_valid/rdata       : one-cycle response strobe from the DM
//   io_err_clr                  : clears the sticky error flags
//   io_busy                     : queue non-empty or an access in flight
//   io_overflow_err             : sticky, a strobe was dropped (queue full)
//   io_timeout_err              : sticky, a response never arrived
module dmi_req_bridge
  import dmi_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                  clock,
  input  logic                  io_core_rst_n,
  input  logic                  io_dmi_reg_en,
  input  logic                  io_dmi_reg_wr_en,
  input  logic [DMI_ADDR_W-1:0] io_dmi_reg_wr_addr,
  input  logic [DMI_DATA_W-1:0] io_dmi_reg_wr_data,
  input  logic                  io_dmi_hard_reset,
  output logic [DMI_DATA_W-1:0] io_dmi_rd_data,
  output logic                  io_dm_req_valid,
  input  logic                  io_dm_req_ready,
  output logic                  io_dm_req_write,
  output logic [DMI_ADDR_W-1:0] io_dm_req_addr,
  output logic [DMI_DATA_W-1:0] io_dm_req_wdata,
  input  logic                  io_dm_rsp_valid,
  input  logic [DMI_DATA_W-1:0] io_dm_rsp_rdata,
  input  logic                  io_err_clr,
  output logic                  io_busy,
  output logic                  io_overflow_err,
  output logic                  io_timeout_err
);

  localparam int         CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e          state, state_nxt;
  logic [15:0]     tmo_cnt;
  dmi_req_t        req_q, fifo_head, fifo_in;
  logic            push, pop, rsp_take, tmo_hit, ovf_set;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_cnt;

  // A strobe coinciding with hard reset is dropped without flagging.
  assign push    = io_dmi_reg_en && !io_dmi_hard_reset;
  assign fifo_in = '{write: io_dmi_reg_wr_en, addr: io_dmi_reg_wr_addr,
                     wdata: io_dmi_reg_wr_data};
  assign ovf_set = push && fifo_full && !pop;

  dmi_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .rst_n (io_core_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (io_dmi_hard_reset),
    .wdata (fifo_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    rsp_take  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (io_dm_req_ready) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        // A response on the final cycle beats the timeout.
        if (io_dm_rsp_valid) begin
          rsp_take  = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!io_core_rst_n) begin
      state           <= IDLE;
      req_q           <= '0;
      tmo_cnt         <= '0;
      io_dmi_rd_data  <= '0;
      io_overflow_err <= 1'b0;
      io_timeout_err  <= 1'b0;
    end else if (io_dmi_hard_reset) begin
      // Read data survives a hard reset; everything else is flushed.
      state           <= IDLE;
      req_q           <= '0;
      tmo_cnt         <= '0;
      io_overflow_err <= 1'b0;
      io_timeout_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) req_q <= fifo_head;
      if (state == REQ && io_dm_req_ready) tmo_cnt <= '0;
      else if (state == WAIT_RSP)          tmo_cnt <= tmo_cnt + 1'b1;
      if (rsp_take && !req_q.write) io_dmi_rd_data <= io_dm_rsp_rdata;
      // Set beats clear when both land in the same cycle.
      io_overflow_err <= ovf_set | (io_overflow_err & ~io_err_clr);
      io_timeout_err  <= tmo_hit | (io_timeout_err & ~io_err_clr);
    end
  end

  assign io_dm_req_valid = (state == REQ);
  assign io_dm_req_write = req_q.write;
  assign io_dm_req_addr  = req_q.addr;
  assign io_dm_req_wdata = req_q.wdata;
  assign io_busy         = (fifo_cnt != '0) || (state != IDLE);

endmodule

// File: tb/tb_dmi_req_bridge.sv
module tb_dmi_req_bridge;

  logic        clock = 1'b0;
  logic        io_core_rst_n;
  logic        io_dmi_reg_en;
  logic        io_dmi_reg_wr_en;
  logic [6:0]  io_dmi_reg_wr_addr;
  logic [31:0] io_dmi_reg_wr_data;
  logic        io_dmi_hard_reset;
  logic [31:0] io_dmi_rd_data;
  logic        io_dm_req_valid;
  logic        io_dm_req_ready;
  logic        io_dm_req_write;
  logic [6:0]  io_dm_req_addr;
  logic [31:0] io_dm_req_wdata;
  logic        io_dm_rsp_valid;
  logic [31:0] io_dm_rsp_rdata;
  logic        io_err_clr;
  logic        io_busy;
  logic        io_overflow_err;
  logic        io_timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dmi_req_bridge #(.TIMEOUT_CYCLES(8), .FIFO_DEPTH(2)) dut (
    .clock              (clock),
    .io_core_rst_n      (io_core_rst_n),
    .io_dmi_reg_en      (io_dmi_reg_en),
    .io_dmi_reg_wr_en   (io_dmi_reg_wr_en),
    .io_dmi_reg_wr_addr (io_dmi_reg_wr_addr),
    .io_dmi_reg_wr_data (io_dmi_reg_wr_data),
    .io_dmi_hard_reset  (io_dmi_hard_reset),
    .io_dmi_rd_data     (io_dmi_rd_data),
    .io_dm_req_valid    (io_dm_req_valid),
    .io_dm_req_ready    (io_dm_req_ready),
    .io_dm_req_write    (io_dm_req_write),
    .io_dm_req_addr     (io_dm_req_addr),
    .io_dm_req_wdata    (io_dm_req_wdata),
    .io_dm_rsp_valid    (io_dm_rsp_valid),
    .io_dm_rsp_rdata    (io_dm_rsp_rdata),
    .io_err_clr         (io_err_clr),
    .io_busy            (io_busy),
    .io_overflow_err    (io_overflow_err),
    .io_timeout_err     (io_timeout_err)
  );

  // Advance one clock; inputs set after this apply at the next edge and
  // outputs read after this show the state of the new cycle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic wr, input logic [6:0] a, input logic [31:0] d);
    io_dmi_reg_en      = 1'b1;
    io_dmi_reg_wr_en   = wr;
    io_dmi_reg_wr_addr = a;
    io_dmi_reg_wr_data = d;
    step();
    io_dmi_reg_en      = 1'b0;
  endtask

  // From a cycle in REQ: accept, respond one cycle later, then stop two
  // cycles after the response (next request valid there if one is queued).
  task automatic complete(input logic [31:0] d);
    io_dm_req_ready = 1'b1;
    step();
    io_dm_req_ready = 1'b0;
    io_dm_rsp_valid = 1'b1;
    io_dm_rsp_rdata = d;
    step();
    io_dm_rsp_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    io_core_rst_n = 1'b0; io_dmi_reg_en = 1'b0; io_dmi_reg_wr_en = 1'b0;
    io_dmi_reg_wr_addr = '0; io_dmi_reg_wr_data = '0; io_dmi_hard_reset = 1'b0;
    io_dm_req_ready = 1'b0; io_dm_rsp_valid = 1'b0; io_dm_rsp_rdata = '0;
    io_err_clr = 1'b0;
    step(); step();
    checks++;
    if ({io_dmi_rd_data, io_dm_req_valid, io_dm_req_write, io_dm_req_addr,
         io_dm_req_wdata, io_busy, io_overflow_err, io_timeout_err} !== 76'd0) begin
      failures++;
      $display("FAIL reset_outputs rd=%h v=%b w=%b a=%h wd=%h busy=%b ovf=%b tmo=%b expected all 0",
               io_dmi_rd_data, io_dm_req_valid, io_dm_req_write, io_dm_req_addr,
               io_dm_req_wdata, io_busy, io_overflow_err, io_timeout_err);
    end
    io_core_rst_n = 1'b1;
    step();
    checks++;
    if (io_busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle busy=%b expected 0", io_busy);
    end
  endtask

  task automatic test_read();
    strobe(1'b0, 7'h11, 32'h0);                        // now cycle 1
    checks++;
    if (io_dm_req_valid !== 1'b0 || io_busy !== 1'b1) begin
      failures++; $display("FAIL read_cycle1 valid=%b busy=%b expected 0/1", io_dm_req_valid, io_busy);
    end
    step();                                            // cycle 2
    checks++;
    if (io_dm_req_valid !== 1'b1 || io_dm_req_addr !== 7'h11 || io_dm_req_write !== 1'b0) begin
      failures++;
      $display("FAIL read_req valid=%b addr=%h write=%b expected 1/11/0",
               io_dm_req_valid, io_dm_req_addr, io_dm_req_write);
    end
    io_dm_req_ready = 1'b1;
    step();                                            // cycle 3, WAIT_RSP
    io_dm_req_ready = 1'b0;
    checks++;
    if (io_dm_req_valid !== 1'b0) begin
      failures++; $display("FAIL read_valid_drop valid=%b expected 0", io_dm_req_valid);
    end
    step();                                            // cycle 4
    io_dm_rsp_valid = 1'b1; io_dm_rsp_rdata = 32'hA5A5_0003;
    step();                                            // cycle 5
    io_dm_rsp_valid = 1'b0;
    checks++;
    if (io_dmi_rd_data !== 32'hA5A5_0003 || io_busy !== 1'b0) begin
      failures++;
      $display("FAIL read_data rd=%h busy=%b expected a5a50003/0", io_dmi_rd_data, io_busy);
    end
  endtask

  task automatic test_write();
    strobe(1'b1, 7'h10, 32'h8000_0001);
    step();
    checks++;
    if (io_dm_req_valid !== 1'b1 || io_dm_req_write !== 1'b1 ||
        io_dm_req_addr !== 7'h10 || io_dm_req_wdata !== 32'h8000_0001) begin
      failures++;
      $display("FAIL write_req valid=%b write=%b addr=%h wdata=%h expected 1/1/10/80000001",
               io_dm_req_valid, io_dm_req_write, io_dm_req_addr, io_dm_req_wdata);
    end
    complete(32'hFFFF_FFFF);
    checks++;
    if (io_dmi_rd_data !== 32'hA5A5_0003 || io_busy !== 1'b0) begin
      failures++;
      $display("FAIL write_keeps_rd rd=%h busy=%b expected a5a50003/0", io_dmi_rd_data, io_busy);
    end
  endtask

  task automatic test_overflow();
    strobe(1'b0, 7'h01, 32'h0);                        // lands in REQ
    strobe(1'b0, 7'h02, 32'h0);                        // queued
    strobe(1'b0, 7'h03, 32'h0);                        // queued, FIFO full
    checks++;
    if (io_overflow_err !== 1'b0) begin
      failures++; $display("FAIL ovf_early ovf=%b expected 0", io_overflow_err);
    end
    io_err_clr = 1'b1;                                 // set must beat clear
    strobe(1'b0, 7'h04, 32'h0);
    io_err_clr = 1'b0;
    checks++;
    if (io_overflow_err !== 1'b1 || io_dm_req_valid !== 1'b1 || io_dm_req_addr !== 7'h01) begin
      failures++;
      $display("FAIL ovf_set ovf=%b valid=%b addr=%h expected 1/1/01",
               io_overflow_err, io_dm_req_valid, io_dm_req_addr);
    end
    io_err_clr = 1'b1;
    step();
    io_err_clr = 1'b0;
    checks++;
    if (io_overflow_err !== 1'b0) begin
      failures++; $display("FAIL ovf_clear ovf=%b expected 0", io_overflow_err);
    end
    complete(32'h1111_0001);
    checks++;
    if (io_dm_req_addr !== 7'h02 || io_dm_req_valid !== 1'b1 || io_dmi_rd_data !== 32'h1111_0001) begin
      failures++;
      $display("FAIL ovf_order2 addr=%h valid=%b rd=%h expected 02/1/11110001",
               io_dm_req_addr, io_dm_req_valid, io_dmi_rd_data);
    end
    complete(32'h2222_0002);
    checks++;
    if (io_dm_req_addr !== 7'h03 || io_dm_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_order3 addr=%h valid=%b expected 03/1", io_dm_req_addr, io_dm_req_valid);
    end
    complete(32'h3333_0003);
    checks++;
    if (io_busy !== 1'b0 || io_dmi_rd_data !== 32'h3333_0003) begin
      failures++;
      $display("FAIL ovf_dropped busy=%b rd=%h expected 0/33330003", io_busy, io_dmi_rd_data);
    end
  endtask

  task automatic test_timeout();
    strobe(1'b0, 7'h20, 32'h0);
    step();                                            // REQ
    io_dm_req_ready = 1'b1;
    step();                                            // first WAIT_RSP cycle
    io_dm_req_ready = 1'b0;
    repeat (7) step();                                 // eighth WAIT_RSP cycle
    checks++;
    if (io_busy !== 1'b1 || io_timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_not_yet busy=%b tmo=%b expected 1/0", io_busy, io_timeout_err);
    end
    step();
    checks++;
    if (io_busy !== 1'b0 || io_timeout_err !== 1'b1 || io_dmi_rd_data !== 32'h3333_0003) begin
      failures++;
      $display("FAIL tmo_fire busy=%b tmo=%b rd=%h expected 0/1/33330003",
               io_busy, io_timeout_err, io_dmi_rd_data);
    end
    io_dm_rsp_valid = 1'b1; io_dm_rsp_rdata = 32'hDEAD_BEEF;
    step();
    io_dm_rsp_valid = 1'b0;
    step();
    checks++;
    if (io_dmi_rd_data !== 32'h3333_0003 || io_busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_late_rsp rd=%h busy=%b expected 33330003/0", io_dmi_rd_data, io_busy);
    end
    io_err_clr = 1'b1;
    step();
    io_err_clr = 1'b0;
    checks++;
    if (io_timeout_err !== 1'b0) begin
      failures++; $display("FAIL tmo_clear tmo=%b expected 0", io_timeout_err);
    end
    // Response on the last allowed cycle wins over the timeout.
    strobe(1'b0, 7'h21, 32'h0);
    step();
    io_dm_req_ready = 1'b1;
    step();
    io_dm_req_ready = 1'b0;
    repeat (7) step();
    io_dm_rsp_valid = 1'b1; io_dm_rsp_rdata = 32'h5A5A_0021;
    step();
    io_dm_rsp_valid = 1'b0;
    checks++;
    if (io_dmi_rd_data !== 32'h5A5A_0021 || io_timeout_err !== 1'b0 || io_busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_rsp_wins rd=%h tmo=%b busy=%b expected 5a5a0021/0/0",
               io_dmi_rd_data, io_timeout_err, io_busy);
    end
  endtask

  task automatic test_hard_reset();
    strobe(1'b1, 7'h41, 32'h0000_0041);
    strobe(1'b0, 7'h42, 32'h0);
    strobe(1'b0, 7'h43, 32'h0);
    strobe(1'b0, 7'h44, 32'h0);                        // overflow sets a flag
    checks++;
    if (io_dm_req_valid !== 1'b1 || io_dm_req_addr !== 7'h41 || io_overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL hr_setup valid=%b addr=%h ovf=%b expected 1/41/1",
               io_dm_req_valid, io_dm_req_addr, io_overflow_err);
    end
    io_dmi_hard_reset = 1'b1;
    strobe(1'b1, 7'h45, 32'h0000_0045);                // dropped silently
    io_dmi_hard_reset = 1'b0;
    checks++;
    if (io_dm_req_valid !== 1'b0 || io_busy !== 1'b0 || io_overflow_err !== 1'b0 ||
        io_timeout_err !== 1'b0 || io_dm_req_addr !== 7'h00 || io_dm_req_wdata !== 32'h0 ||
        io_dmi_rd_data !== 32'h5A5A_0021) begin
      failures++;
      $display("FAIL hr_flush valid=%b busy=%b ovf=%b tmo=%b addr=%h wd=%h rd=%h expected 0/0/0/0/00/0/5a5a0021",
               io_dm_req_valid, io_busy, io_overflow_err, io_timeout_err,
               io_dm_req_addr, io_dm_req_wdata, io_dmi_rd_data);
    end
    step(); step();
    checks++;
    if (io_busy !== 1'b0 || io_dm_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL hr_strobe_dropped busy=%b valid=%b expected 0/0", io_busy, io_dm_req_valid);
    end
  endtask

  task automatic test_back_to_back();
    strobe(1'b0, 7'h31, 32'h0);
    strobe(1'b0, 7'h32, 32'h0);
    strobe(1'b0, 7'h33, 32'h0);                        // REQ + 2 queued
    io_dm_req_ready = 1'b1;
    step();
    io_dm_req_ready = 1'b0;
    io_dm_rsp_valid = 1'b1; io_dm_rsp_rdata = 32'h4444_0031;
    step();                                            // IDLE, full FIFO pops now
    io_dm_rsp_valid = 1'b0;
    strobe(1'b0, 7'h34, 32'h0);                        // push alongside the pop
    checks++;
    if (io_overflow_err !== 1'b0 || io_dm_req_addr !== 7'h32 || io_dm_req_valid !== 1'b1 ||
        io_dmi_rd_data !== 32'h4444_0031) begin
      failures++;
      $display("FAIL b2b_accept ovf=%b addr=%h valid=%b rd=%h expected 0/32/1/44440031",
               io_overflow_err, io_dm_req_addr, io_dm_req_valid, io_dmi_rd_data);
    end
    complete(32'h4444_0032);
    checks++;
    if (io_dm_req_addr !== 7'h33) begin
      failures++; $display("FAIL b2b_order3 addr=%h expected 33", io_dm_req_addr);
    end
    complete(32'h4444_0033);
    checks++;
    if (io_dm_req_addr !== 7'h34 || io_dm_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_order4 addr=%h valid=%b expected 34/1", io_dm_req_addr, io_dm_req_valid);
    end
    complete(32'h4444_0034);
    checks++;
    if (io_busy !== 1'b0 || io_dmi_rd_data !== 32'h4444_0034 || io_overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain busy=%b rd=%h ovf=%b expected 0/44440034/0",
               io_busy, io_dmi_rd_data, io_overflow_err);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_overflow();
    test_timeout();
    test_hard_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
